// File: rtl/lpif_gearbox_pkg.sv
// Shared widths, field offsets and beat layout for the quarter-rate LPIF gearbox.
package lpif_gearbox_pkg;

    localparam int unsigned BEAT_W    = 145;
    localparam int unsigned NUM_SLOTS = 4;
    localparam int unsigned WORD_W    = BEAT_W * NUM_SLOTS;

    localparam int unsigned STATE_OFF     = 0;
    localparam int unsigned PROTID_OFF    = 4;
    localparam int unsigned DATA_OFF      = 6;
    localparam int unsigned DVALID_OFF    = 134;
    localparam int unsigned CRC_OFF       = 135;
    localparam int unsigned CRC_VALID_OFF = 143;
    localparam int unsigned VALID_OFF     = 144;

    // Declared MSB first so the struct overlays the raw 145-bit beat.
    typedef struct packed {
        logic         valid;
        logic         crc_valid;
        logic [7:0]   crc;
        logic         dvalid;
        logic [127:0] data;
        logic [1:0]   protid;
        logic [3:0]   state;
    } lpif_beat_t;

endpackage

// File: rtl/lpif_txrx_x8_asym2_quarter_master_gearbox_if.sv
// Beat-side and FIFO-side signal bundle for the quarter-rate LPIF gearbox.
interface lpif_txrx_x8_asym2_quarter_master_gearbox_if;
    import lpif_gearbox_pkg::*;

    logic [BEAT_W-1:0] ustrm_beat;
    logic              ustrm_beat_vld;
    logic              ustrm_beat_rdy;
    logic [WORD_W-1:0] txfifo_upstream_data;
    logic              txfifo_push;
    logic              txfifo_full;
    logic [WORD_W-1:0] rxfifo_downstream_data;
    logic              rxfifo_pop;
    logic              rxfifo_empty;
    logic [BEAT_W-1:0] dstrm_beat;
    logic              dstrm_beat_vld;
    logic              dstrm_beat_rdy;
    logic              flush;

    modport master (
        input  ustrm_beat, ustrm_beat_vld, txfifo_full, rxfifo_downstream_data, rxfifo_empty,
        input  dstrm_beat_rdy, flush,
        output ustrm_beat_rdy, txfifo_upstream_data, txfifo_push, rxfifo_pop, dstrm_beat,
        output dstrm_beat_vld
    );

    modport slave (
        output ustrm_beat, ustrm_beat_vld, txfifo_full, rxfifo_downstream_data, rxfifo_empty,
        output dstrm_beat_rdy, flush,
        input  ustrm_beat_rdy, txfifo_upstream_data, txfifo_push, rxfifo_pop, dstrm_beat,
        input  dstrm_beat_vld
    );

endinterface

// File: rtl/lpif_quarter_unpack.sv
// RX unpacker: pops one 4-beat word from a show-ahead FIFO and replays it a beat at a time.
module lpif_quarter_unpack
    import lpif_gearbox_pkg::*;
(
    input  logic              clk_wr,
    input  logic              rst_wr,
    input  logic [WORD_W-1:0] rxfifo_downstream_data,
    input  logic              rxfifo_empty,
    output logic              rxfifo_pop,
    output logic [BEAT_W-1:0] dstrm_beat,
    output logic              dstrm_beat_vld,
    input  logic              dstrm_beat_rdy
);

    lpif_beat_t [NUM_SLOTS-1:0] word_q;
    logic [1:0]                 rx_slot_q;
    logic                       rx_loaded_q;
    logic                       rx_hs;

    assign rx_hs = rx_loaded_q & dstrm_beat_rdy;

    // Reloading on the last handshake keeps the beat stream bubble-free.
    assign rxfifo_pop = ~rst_wr & ~rxfifo_empty &
                        (~rx_loaded_q | (rx_hs & (rx_slot_q == 2'd3)));

    assign dstrm_beat_vld = ~rst_wr & rx_loaded_q;
    assign dstrm_beat     = rst_wr ? '0 : word_q[rx_slot_q];

    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            word_q      <= '0;
            rx_slot_q   <= 2'd0;
            rx_loaded_q <= 1'b0;
        end else if (rxfifo_pop) begin
            word_q      <= rxfifo_downstream_data;
            rx_slot_q   <= 2'd0;
            rx_loaded_q <= 1'b1;
        end else if (rx_hs) begin
            rx_slot_q <= rx_slot_q + 2'd1;
            if (rx_slot_q == 2'd3) begin
                rx_loaded_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/lpif_txrx_x8_asym2_quarter_master_gearbox.sv
// Quarter-rate LPIF gearbox: packs 4 TX beats per FIFO word, unpacks RX words into beats.
// Optional partial-word flush is built when LPIF_GEARBOX_FLUSH_EN is defined.
module lpif_txrx_x8_asym2_quarter_master_gearbox
    import lpif_gearbox_pkg::*;
#(
    parameter int unsigned FLUSH_TIMEOUT = 16
) (
    input logic clk_wr,
    input logic rst_wr,
    lpif_txrx_x8_asym2_quarter_master_gearbox_if.master bus
);

    lpif_beat_t [NUM_SLOTS-2:0] acc_q;
    lpif_beat_t [NUM_SLOTS-1:0] load_data;
    logic [1:0]                 tx_slot_q;
    logic [WORD_W-1:0]          hold_q;
    logic                       tx_pending_q;
    logic                       tx_accept;
    logic                       tx_push;
    logic                       load_full;
    logic                       load_word;
    logic                       flush_fire;

    assign bus.ustrm_beat_rdy = ~rst_wr & ~((tx_slot_q == 2'd3) & tx_pending_q & bus.txfifo_full);
    assign tx_accept          = bus.ustrm_beat_vld & bus.ustrm_beat_rdy;
    assign tx_push            = ~rst_wr & tx_pending_q & ~bus.txfifo_full;
    assign load_full          = tx_accept & (tx_slot_q == 2'd3);
    assign load_word          = load_full | flush_fire;

    assign bus.txfifo_push          = tx_push;
    assign bus.txfifo_upstream_data = rst_wr ? '0 : hold_q;

`ifdef LPIF_GEARBOX_FLUSH_EN
    localparam int unsigned CntW = $clog2(FLUSH_TIMEOUT + 1);

    logic [CntW-1:0] idle_cnt_q;
    logic            timed_out;

    assign timed_out  = idle_cnt_q == CntW'(FLUSH_TIMEOUT - 1);
    // Only fire when the holding register is free (or draining this cycle).
    assign flush_fire = (tx_slot_q != 2'd0) & ~tx_accept & (bus.flush | timed_out) &
                        (~tx_pending_q | tx_push);

    always_ff @(posedge clk_wr) begin
        if (rst_wr || tx_accept || (tx_slot_q == 2'd0)) begin
            idle_cnt_q <= '0;
        end else if (!timed_out) begin
            idle_cnt_q <= idle_cnt_q + CntW'(1);
        end
    end
`else
    logic unused_flush;

    assign unused_flush = bus.flush ^ (FLUSH_TIMEOUT != 0);
    assign flush_fire   = 1'b0;
`endif

    // Slots at or beyond tx_slot are zero, which pads a flushed partial word.
    always_comb begin
        load_data = '0;
        for (int k = 0; k < NUM_SLOTS - 1; k++) begin
            if (2'(k) < tx_slot_q) begin
                load_data[k] = acc_q[k];
            end
        end
        if (load_full) begin
            load_data[NUM_SLOTS-1] = bus.ustrm_beat;
        end
    end

    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            acc_q        <= '0;
            tx_slot_q    <= 2'd0;
            hold_q       <= '0;
            tx_pending_q <= 1'b0;
        end else begin
            if (tx_accept && (tx_slot_q != 2'd3)) begin
                acc_q[tx_slot_q] <= bus.ustrm_beat;
            end
            if (flush_fire) begin
                tx_slot_q <= 2'd0;
            end else if (tx_accept) begin
                tx_slot_q <= tx_slot_q + 2'd1;
            end
            if (load_word) begin
                hold_q       <= load_data;
                tx_pending_q <= 1'b1;
            end else if (tx_push) begin
                tx_pending_q <= 1'b0;
            end
        end
    end

    lpif_quarter_unpack u_unpack (
        .clk_wr                 (clk_wr),
        .rst_wr                 (rst_wr),
        .rxfifo_downstream_data (bus.rxfifo_downstream_data),
        .rxfifo_empty           (bus.rxfifo_empty),
        .rxfifo_pop             (bus.rxfifo_pop),
        .dstrm_beat             (bus.dstrm_beat),
        .dstrm_beat_vld         (bus.dstrm_beat_vld),
        .dstrm_beat_rdy         (bus.dstrm_beat_rdy)
    );

endmodule

// File: tb/tb_lpif_txrx_x8_asym2_quarter_master_gearbox.sv
// Bench for the quarter-rate LPIF gearbox: queue-based beat/word model plus directed scenarios.
module tb_lpif_txrx_x8_asym2_quarter_master_gearbox;
    import lpif_gearbox_pkg::*;

    localparam int unsigned FLUSH_TIMEOUT = 16;

    logic clk_wr = 1'b0;
    logic rst_wr;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    lpif_txrx_x8_asym2_quarter_master_gearbox_if bus ();

    lpif_txrx_x8_asym2_quarter_master_gearbox #(
        .FLUSH_TIMEOUT (FLUSH_TIMEOUT)
    ) dut (
        .clk_wr (clk_wr),
        .rst_wr (rst_wr),
        .bus    (bus)
    );

    always #5 clk_wr = ~clk_wr;
    always @(posedge clk_wr) cyc <= cyc + 1;

    // Environment-side RX FIFO (show-ahead).
    logic [WORD_W-1:0] rx_mem [16];
    int                rx_wr = 0;
    int                rx_rd = 0;
    int                rx_pops = 0;
    assign bus.rxfifo_empty           = (rx_wr == rx_rd);
    assign bus.rxfifo_downstream_data = rx_mem[rx_rd % 16];

    // Model state: beats collected toward the next word, words awaiting push, beats owed downstream.
    logic [BEAT_W-1:0] m_part [$];
    logic [WORD_W-1:0] m_words [$];
    logic [BEAT_W-1:0] m_rx [$];
    int                m_idle = 0;
    logic [WORD_W-1:0] push_data [$];
    int                push_cyc [$];

    task automatic chk(input string name, input logic [WORD_W-1:0] act,
                       input logic [WORD_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic logic [BEAT_W-1:0] make_beat(input int idx);
        logic [BEAT_W-1:0] b = '0;
        b[STATE_OFF +: 4]  = idx[3:0];
        b[PROTID_OFF +: 2] = idx[1:0];
        b[DATA_OFF +: 128] = 128'(idx);
        b[DVALID_OFF]      = 1'b1;
        b[CRC_OFF +: 8]    = idx[7:0] ^ 8'h5a;
        b[CRC_VALID_OFF]   = 1'b1;
        b[VALID_OFF]       = 1'b1;
        return b;
    endfunction

    function automatic logic [WORD_W-1:0] make_word(input int base);
        logic [WORD_W-1:0] w = '0;
        for (int k = 0; k < 4; k++) w[k*BEAT_W +: BEAT_W] = make_beat(base + k);
        return w;
    endfunction

    function automatic int slot_data(input logic [WORD_W-1:0] w, input int k);
        return int'(w[k*BEAT_W + DATA_OFF +: 32]);
    endfunction

    // Single compare process: checks every output each cycle, then advances the model.
    initial begin
        logic              exp_rdy, acc, exp_push, exp_vld, rx_hs, exp_pop, pop_s, fire;
        logic [BEAT_W-1:0] beat_s;
        logic [WORD_W-1:0] w;
        forever begin
            @(negedge clk_wr);
            if (rst_wr) begin
                chk("rst_push", WORD_W'(bus.txfifo_push), '0);
                chk("rst_pop", WORD_W'(bus.rxfifo_pop), '0);
                chk("rst_dvld", WORD_W'(bus.dstrm_beat_vld), '0);
                chk("rst_urdy", WORD_W'(bus.ustrm_beat_rdy), '0);
                chk("rst_txdata", bus.txfifo_upstream_data, '0);
                chk("rst_dbeat", WORD_W'(bus.dstrm_beat), '0);
                m_part.delete();
                m_words.delete();
                m_rx.delete();
                m_idle = 0;
            end else begin
                exp_rdy = !(m_part.size() == 3 && m_words.size() != 0 && bus.txfifo_full);
                chk("tx_rdy", WORD_W'(bus.ustrm_beat_rdy), WORD_W'(exp_rdy));
                acc    = bus.ustrm_beat_vld && exp_rdy;
                beat_s = bus.ustrm_beat;
                exp_push = m_words.size() != 0 && !bus.txfifo_full;
                chk("tx_push", WORD_W'(bus.txfifo_push), WORD_W'(exp_push));
                if (exp_push && bus.txfifo_push) chk("tx_word", bus.txfifo_upstream_data, m_words[0]);
                if (bus.txfifo_push) begin
                    push_data.push_back(bus.txfifo_upstream_data);
                    push_cyc.push_back(cyc);
                end
                fire = 1'b0;
`ifdef LPIF_GEARBOX_FLUSH_EN
                fire = m_part.size() != 0 && !acc &&
                       (bus.flush || m_idle + 1 >= int'(FLUSH_TIMEOUT)) &&
                       (m_words.size() == 0 || exp_push);
`endif
                exp_vld = m_rx.size() != 0;
                chk("rx_vld", WORD_W'(bus.dstrm_beat_vld), WORD_W'(exp_vld));
                if (exp_vld && bus.dstrm_beat_vld) chk("rx_beat", WORD_W'(bus.dstrm_beat), WORD_W'(m_rx[0]));
                rx_hs   = exp_vld && bus.dstrm_beat_rdy;
                exp_pop = !bus.rxfifo_empty && (m_rx.size() == 0 || (m_rx.size() == 1 && rx_hs));
                chk("rx_pop", WORD_W'(bus.rxfifo_pop), WORD_W'(exp_pop));
                pop_s = bus.rxfifo_pop;

                @(posedge clk_wr);
                #1;
                if (exp_push) void'(m_words.pop_front());
                if (acc || m_part.size() == 0 || fire) m_idle = 0;
                else m_idle++;
                if (acc) m_part.push_back(beat_s);
                if (m_part.size() == 4 || fire) begin
                    w = '0;
                    foreach (m_part[k]) w[k*BEAT_W +: BEAT_W] = m_part[k];
                    m_words.push_back(w);
                    m_part.delete();
                end
                if (rx_hs) void'(m_rx.pop_front());
                if (exp_pop) begin
                    w = rx_mem[rx_rd % 16];
                    for (int k = 0; k < 4; k++) m_rx.push_back(w[k*BEAT_W +: BEAT_W]);
                end
                if (pop_s) begin
                    rx_rd++;
                    rx_pops++;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_wr);
            #1;
        end
    endtask

    // Offers n beats base..base+n-1; txfifo_full held for the first full_cyc cycles.
    task automatic send_tx(input int base, input int n, input int full_cyc, output int low_idx);
        int   i = 0;
        int   c = 0;
        logic ok;
        low_idx = -1;
        while (i < n) begin
            bus.ustrm_beat     = make_beat(base + i);
            bus.ustrm_beat_vld = 1'b1;
            bus.txfifo_full    = (c < full_cyc);
            @(negedge clk_wr);
            ok = bus.ustrm_beat_rdy;
            if (!ok && low_idx < 0) low_idx = i;
            @(posedge clk_wr);
            #1;
            if (ok) i++;
            c++;
            if (c > 100) begin
                n_cmp++;
                n_bad++;
                $display("FAIL tx_send_timeout: got %0d beats, want %0d", i, n);
                break;
            end
        end
        bus.ustrm_beat_vld = 1'b0;
        bus.txfifo_full    = 1'b0;
    endtask

    task automatic scen_tx_b2b();
        int p0, s, low;
        p0 = push_data.size();
        s  = cyc;
        send_tx(0, 8, 0, low);
        idle(3);
        chk("b2b_push_count", WORD_W'(push_data.size() - p0), WORD_W'(2));
        if (push_data.size() - p0 == 2) begin
            chk("b2b_push0_cyc", WORD_W'(push_cyc[p0]), WORD_W'(s + 4));
            chk("b2b_push1_cyc", WORD_W'(push_cyc[p0 + 1]), WORD_W'(s + 8));
            for (int k = 0; k < 4; k++)
                chk("b2b_word0_slot", WORD_W'(slot_data(push_data[p0], k)), WORD_W'(k));
            chk("b2b_word1_slot0", WORD_W'(slot_data(push_data[p0 + 1], 0)), WORD_W'(4));
        end
    endtask

    task automatic scen_rx_stream();
        int p0, run, w;
        p0 = rx_pops;
        for (int j = 0; j < 3; j++) rx_mem[(rx_wr + j) % 16] = make_word(100 + 4 * j);
        rx_wr += 3;
        bus.dstrm_beat_rdy = 1'b1;
        w = 0;
        @(negedge clk_wr);
        while (!bus.dstrm_beat_vld && w < 10) begin
            @(posedge clk_wr);
            #1;
            w++;
            @(negedge clk_wr);
        end
        run = 0;
        for (int j = 0; j < 12; j++) begin
            if (bus.dstrm_beat_vld) run++;
            @(posedge clk_wr);
            #1;
            @(negedge clk_wr);
        end
        chk("rx_stream_after_vld", WORD_W'(bus.dstrm_beat_vld), '0);
        @(posedge clk_wr);
        #1;
        chk("rx_stream_run", WORD_W'(run), WORD_W'(12));
        chk("rx_stream_pops", WORD_W'(rx_pops - p0), WORD_W'(3));
    endtask

    task automatic scen_rx_toggle();
        int got [4];
        int n = 0;
        int c = 0;
        rx_mem[rx_wr % 16] = make_word(200);
        rx_wr++;
        while (n < 4 && c < 40) begin
            bus.dstrm_beat_rdy = (c % 2 == 0);
            @(negedge clk_wr);
            if (bus.dstrm_beat_vld && bus.dstrm_beat_rdy) begin
                got[n] = int'(bus.dstrm_beat[DATA_OFF +: 32]);
                n++;
            end
            @(posedge clk_wr);
            #1;
            c++;
        end
        bus.dstrm_beat_rdy = 1'b1;
        chk("rx_toggle_count", WORD_W'(n), WORD_W'(4));
        for (int k = 0; k < 4; k++)
            if (k < n) chk("rx_toggle_order", WORD_W'(got[k]), WORD_W'(200 + k));
    endtask

    initial begin
        int p0, s, low;
        rst_wr             = 1'b1;
        bus.ustrm_beat     = '0;
        bus.ustrm_beat_vld = 1'b0;
        bus.txfifo_full    = 1'b0;
        bus.dstrm_beat_rdy = 1'b0;
        bus.flush          = 1'b0;
        for (int j = 0; j < 16; j++) rx_mem[j] = '0;
        repeat (3) @(posedge clk_wr);
        #1;
        rst_wr = 1'b0;
        idle(1);

        // TX and RX run concurrently to show the paths do not interact.
        fork
            scen_tx_b2b();
            scen_rx_stream();
        join

        // Backpressure: full for 10 cycles while 8 beats are offered.
        p0 = push_data.size();
        send_tx(20, 8, 10, low);
        idle(3);
        chk("bp_rdy_low_beat", WORD_W'(low), WORD_W'(7));
        chk("bp_push_count", WORD_W'(push_data.size() - p0), WORD_W'(2));
        if (push_data.size() - p0 == 2) begin
            chk("bp_word0_slot3", WORD_W'(slot_data(push_data[p0], 3)), WORD_W'(23));
            chk("bp_word1_slot3", WORD_W'(slot_data(push_data[p0 + 1], 3)), WORD_W'(27));
        end

        scen_rx_toggle();

        // Reset mid-word drops the partial beats.
        send_tx(300, 2, 0, low);
        rst_wr = 1'b1;
        idle(1);
        rst_wr = 1'b0;
        p0 = push_data.size();
        send_tx(400, 4, 0, low);
        idle(3);
        chk("rst_mid_push_count", WORD_W'(push_data.size() - p0), WORD_W'(1));
        if (push_data.size() - p0 == 1)
            for (int k = 0; k < 4; k++)
                chk("rst_mid_slot", WORD_W'(slot_data(push_data[p0], k)), WORD_W'(400 + k));

`ifdef LPIF_GEARBOX_FLUSH_EN
        p0 = push_data.size();
        s  = cyc;
        send_tx(500, 2, 0, low);
        idle(20);
        chk("to_push_count", WORD_W'(push_data.size() - p0), WORD_W'(1));
        if (push_data.size() - p0 == 1) begin
            chk("to_push_cyc", WORD_W'(push_cyc[p0]), WORD_W'(s + 1 + FLUSH_TIMEOUT + 1));
            chk("to_slot1", WORD_W'(slot_data(push_data[p0], 1)), WORD_W'(501));
            chk("to_slot2_zero", WORD_W'(push_data[p0][2*BEAT_W +: BEAT_W]), '0);
            chk("to_slot3_zero", WORD_W'(push_data[p0][3*BEAT_W +: BEAT_W]), '0);
        end
        p0 = push_data.size();
        s  = cyc;
        send_tx(600, 1, 0, low);
        bus.flush = 1'b1;
        idle(1);
        bus.flush = 1'b0;
        idle(3);
        chk("fl_push_count", WORD_W'(push_data.size() - p0), WORD_W'(1));
        if (push_data.size() - p0 == 1) begin
            chk("fl_push_cyc", WORD_W'(push_cyc[p0]), WORD_W'(s + 2));
            chk("fl_slot0", WORD_W'(slot_data(push_data[p0], 0)), WORD_W'(600));
            chk("fl_slot1_zero", WORD_W'(push_data[p0][BEAT_W +: BEAT_W]), '0);
        end
`else
        // Without the flush feature a partial word waits for completion.
        p0 = push_data.size();
        send_tx(500, 2, 0, low);
        bus.flush = 1'b1;
        idle(1);
        bus.flush = 1'b0;
        idle(20);
        chk("noflush_push_count", WORD_W'(push_data.size() - p0), '0);
        send_tx(502, 2, 0, low);
        idle(3);
        chk("noflush_done_count", WORD_W'(push_data.size() - p0), WORD_W'(1));
        if (push_data.size() - p0 == 1)
            for (int k = 0; k < 4; k++)
                chk("noflush_slot", WORD_W'(slot_data(push_data[p0], k)), WORD_W'(500 + k));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by %0t, want finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/lpif_txrx_x8_asym2_quarter_master_gearbox.md
LPIF_TXRX_X8_ASYM2_QUARTER_MASTER_GEARBOX -- requirements
Module: lpif_txrx_x8_asym2_quarter_master_gearbox

Interface
REQ-001 SHALL have parameter FLUSH_TIMEOUT, default 16: idle cycles before a partial TX word is flushed (used only with the flush feature).
REQ-002 SHALL use one clock and one synchronous, active-high reset, named as below.
REQ-003 SHALL have port clk_wr, input, 1 bit: sole clock; all state on rising edge.
REQ-004 SHALL have port rst_wr, input, 1 bit: synchronous reset, active high.
REQ-005 SHALL have port ustrm_beat, input, 145 bits: one full-rate LPIF beat.
REQ-006 SHALL have port ustrm_beat_vld / ustrm_beat_rdy, input / output, 1 bit each: TX beat handshake.
REQ-007 SHALL have port txfifo_upstream_data, output, 580 bits: packed quarter-rate word.
REQ-008 SHALL have port txfifo_push / txfifo_full, output / input, 1 bit each: TX FIFO write side.
REQ-009 SHALL have port rxfifo_downstream_data, input, 580 bits: show-ahead RX FIFO head word.
REQ-010 SHALL have port rxfifo_pop / rxfifo_empty, output / input, 1 bit each: RX FIFO read side.
REQ-011 SHALL have port dstrm_beat, output, 145 bits, plus dstrm_beat_vld / dstrm_beat_rdy, output / input: RX beat handshake.
REQ-012 SHALL have port flush, input, 1 bit: request to emit a partial TX word (flush feature only).

Function
REQ-013 Beat layout SHALL be [0+:4] state, [4+:2] protid, [6+:128] data, [134] dvalid, [135+:8] crc, [143] crc_valid, [144] valid; slot k of a word SHALL occupy bits [145k +: 145], k = 0..3.
REQ-014 TX: a beat transfers when vld&rdy; it SHALL be written to accumulator slot tx_slot, and tx_slot SHALL increment mod 4.
REQ-015 TX: the transfer filling slot 3 SHALL move the full word to the output holding register next cycle, setting tx_pending; tx_slot SHALL wrap to 0.
REQ-016 txfifo_push SHALL equal tx_pending & ~txfifo_full; a push SHALL clear tx_pending unless a new word is loaded the same cycle.
REQ-017 ustrm_beat_rdy SHALL be 0 only when tx_slot==3 and tx_pending and txfifo_full; otherwise 1. This gives back-to-back 1 beat/cycle with a non-full FIFO.
REQ-018 TX latency SHALL be exactly 1 cycle from the slot-3 transfer to txfifo_push, if the FIFO is not full.
REQ-019 RX: while rx_loaded==0 and ~rxfifo_empty, rxfifo_pop SHALL assert and the head word SHALL be captured into the RX shift register; rx_loaded SHALL be set and rx_slot SHALL be set to 0.
REQ-020 RX: dstrm_beat_vld SHALL equal rx_loaded; dstrm_beat SHALL be slot rx_slot; each vld&rdy SHALL advance rx_slot.
REQ-021 RX: on the slot-3 handshake, if ~rxfifo_empty, a pop and reload SHALL occur in the same cycle (no bubble); otherwise rx_loaded SHALL clear.
REQ-022 rxfifo_pop SHALL never assert when rxfifo_empty is 1.
REQ-023 dstrm_beat_rdy low SHALL hold dstrm_beat and rx_slot stable.
REQ-024 The TX and RX paths SHALL be fully independent; simultaneous activity SHALL not stall either path.

Reset
REQ-025 Reset SHALL clear tx_slot, tx_pending, rx_slot, rx_loaded and the idle counter, and SHALL discard any partial word.
REQ-026 During reset: txfifo_push=0, rxfifo_pop=0, dstrm_beat_vld=0, ustrm_beat_rdy=0, txfifo_upstream_data=0, dstrm_beat=0.
REQ-027 Reset asserted mid-word SHALL drop the partial data; the first beat after reset SHALL go to slot 0.

Configuration
REQ-028 Macro LPIF_GEARBOX_FLUSH_EN SHALL control partial-word flush. When defined: if tx_slot!=0, then either flush=1 or FLUSH_TIMEOUT consecutive cycles with no TX transfer SHALL cause the partial word to be emitted. Unfilled slots SHALL be zero (valid bit 0). tx_slot SHALL reset to 0. flush with tx_slot==0 SHALL be ignored.
REQ-029 Without the macro: the flush input SHALL be ignored, no idle counter SHALL exist, and only full 4-beat words SHALL be pushed.

Structure
REQ-030 The shared package lpif_gearbox_pkg SHALL hold localparams BEAT_W=145, NUM_SLOTS=4, WORD_W=580, the field offsets, and a packed struct lpif_beat_t.
REQ-031 The RX unpacker SHALL be a sub-module lpif_quarter_unpack; the TX packer SHALL remain in the top level.

Verification
REQ-032 Scenario: 8 back-to-back beats, data=beat index, txfifo_full=0 -> 2 pushes, 1 cycle after beats 3 and 7; word0 slot k data = k.
REQ-033 Scenario: txfifo_full=1 held for 10 cycles while 8 beats are offered -> rdy drops at beat 7. After full deasserts: push word0, then word1, with no beat lost or duplicated.
REQ-034 Scenario: 3 RX words preloaded, dstrm_beat_rdy=1 -> 12 consecutive valid beats with no bubble and exactly 3 pops.
REQ-035 Scenario: dstrm_beat_rdy toggled 1/0 during RX -> each beat held while rdy=0, and slot order is 0,1,2,3.
REQ-036 Scenario: rst_wr pulsed after 2 TX beats, then 4 new beats -> exactly one push, containing only the post-reset beats.
REQ-037 Scenario (LPIF_GEARBOX_FLUSH_EN): 2 beats then idle -> push after FLUSH_TIMEOUT=16 cycles, with slots 2 and 3 zero; flush=1 after 1 beat -> push on the next cycle.
